// File: rtl/output_buffer.sv
`default_nettype none
// ============================================================================
// Module   : output_buffer
// Brief    : Result-side buffer for the systolic array. Realigns skewed column
//            results into whole rows and queues them in a circular FIFO that
//            the host drains with an i_rd / o_data handshake.
//            Optional feature macro: OUTPUT_BUFFER_RELU_EN (clamps negative
//            lanes to zero before the FIFO write).
// Revision : 1.0 - initial release
// ============================================================================
module output_buffer #(
    parameter int NUM_COLS   = 3,
    parameter int ACC_WIDTH  = 16,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_wr,
    input  logic [NUM_COLS*ACC_WIDTH-1:0] i_wr_data,
    input  logic                          i_rd,
    output logic [NUM_COLS*ACC_WIDTH-1:0] o_data,
    output logic                          o_valid,
    output logic                          o_empty,
    output logic                          o_full,
    output logic [ADDR_WIDTH:0]           o_count,
    output logic                          o_overflow
);

    localparam int                  ROW_W      = NUM_COLS * ACC_WIDTH;
    localparam int                  DEPTH      = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    // ------------------------------------------------------------------------
    // Deskew: lane j arrives j cycles after the row start, so it is delayed by
    // NUM_COLS-1-j registers; the last lane goes straight through. All lanes
    // therefore line up on the edge that samples the last lane.
    // ------------------------------------------------------------------------
    logic [ROW_W-1:0] w_aligned;
    logic             w_commit;

    for (genvar j = 0; j < NUM_COLS; j++) begin : g_deskew
        localparam int STAGES = NUM_COLS - 1 - j;
        if (STAGES == 0) begin : g_pass
            assign w_aligned[j*ACC_WIDTH +: ACC_WIDTH] = i_wr_data[j*ACC_WIDTH +: ACC_WIDTH];
        end else begin : g_delay
            logic [ACC_WIDTH-1:0] lane_q [STAGES];

            // Lane delay line; contents are qualified by the row-start pipeline so no reset.
            always_ff @(posedge i_clk) begin
                lane_q[0] <= i_wr_data[j*ACC_WIDTH +: ACC_WIDTH];
                for (int k = 1; k < STAGES; k++) begin
                    lane_q[k] <= lane_q[k-1];
                end
            end

            assign w_aligned[j*ACC_WIDTH +: ACC_WIDTH] = lane_q[STAGES-1];
        end
    end

    // Row-start marker travels alongside the data so it emerges with the aligned row.
    if (NUM_COLS > 1) begin : g_wr_pipe
        logic [NUM_COLS-2:0] wr_pipe_q;

        // Row-start shift register; cleared on reset so in-flight rows are discarded.
        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                wr_pipe_q <= '0;
            end else begin
                wr_pipe_q[0] <= i_wr;
                for (int k = 1; k < NUM_COLS - 1; k++) begin
                    wr_pipe_q[k] <= wr_pipe_q[k-1];
                end
            end
        end

        assign w_commit = wr_pipe_q[NUM_COLS-2];
    end else begin : g_wr_direct
        assign w_commit = i_wr;
    end

    // ------------------------------------------------------------------------
    // Optional rectification of the aligned row (purely combinational).
    // ------------------------------------------------------------------------
    logic [ROW_W-1:0] w_row;

`ifdef OUTPUT_BUFFER_RELU_EN
    for (genvar j = 0; j < NUM_COLS; j++) begin : g_relu
        // Lanes are signed; a set MSB means negative and is clamped to zero.
        assign w_row[j*ACC_WIDTH +: ACC_WIDTH] =
            w_aligned[j*ACC_WIDTH + ACC_WIDTH - 1] ? '0 : w_aligned[j*ACC_WIDTH +: ACC_WIDTH];
    end
`else
    assign w_row = w_aligned;
`endif

    // ------------------------------------------------------------------------
    // FIFO storage and control
    // ------------------------------------------------------------------------
    logic [ROW_W-1:0]      mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr_q,     wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q,     rptr_d;
    logic [ADDR_WIDTH:0]   count_q,    count_d;
    logic [ROW_W-1:0]      data_q,     data_d;
    logic                  valid_q,    valid_d;
    logic                  overflow_q, overflow_d;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;

    // Next-state decode: a pop on the same edge frees a slot for a commit when
    // full, while a pop on an empty FIFO never bypasses the incoming row.
    always_comb begin
        w_pop      = i_rd && (count_q != '0);
        w_push     = w_commit && ((count_q != FULL_COUNT) || w_pop);
        w_drop     = w_commit && (count_q == FULL_COUNT) && !w_pop;

        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        data_d     = data_q;
        valid_d    = w_pop;
        overflow_d = overflow_q | w_drop;

        if (w_push) begin
            wptr_d = wptr_q + ADDR_WIDTH'(1);
        end
        if (w_pop) begin
            rptr_d = rptr_q + ADDR_WIDTH'(1);
            data_d = mem_q[rptr_q];
        end

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    // Row storage; not reset, reads are gated by the count.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_push) begin
            mem_q[wptr_q] <= w_row;
        end
    end

    assign o_data     = data_q;
    assign o_valid    = valid_q;
    assign o_count    = count_q;
    assign o_empty    = (count_q == '0);
    assign o_full     = (count_q == FULL_COUNT);
    assign o_overflow = overflow_q;

endmodule
`default_nettype wire
